pipe_stall_ctrl: RTL
====================

Name: pipe_stall_ctrl

Overview:
- Central stall/flush controller for the five-stage MIPS pipeline.
- Generates the F/D write enables and the E-stage bubble from three inputs:
  - register data hazards, using Tuse/Tnew comparison;
  - multiply/divide unit occupancy, tracked here with a cycle counter;
  - eret-vs-mtc0 EPC ordering.
- Exception request from CP0 (M stage) overrides all stalls and cancels a mult/div starting in E the same cycle.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu issue.
- DIV_CYCLES, 10, busy cycles after div/divu issue.
- CNT_W, 4, MDU counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- Req  in  1  exception/interrupt request from CP0; flush-all this cycle.
- rsD  in  5  rs index of instruction in D.
- rtD  in  5  rt index of instruction in D.
- tuseRsD  in  2  cycles until rs needed (3 = unused).
- tuseRtD  in  2  cycles until rt needed (3 = unused).
- a3E  in  5  destination register of instruction in E (0 = none).
- tnewE  in  2  cycles until E result available.
- a3M  in  5  destination register in M.
- tnewM  in  2  cycles until M result available.
- mdD  in  1  D instruction uses MDU (mult/div/mfhi/mflo/mthi/mtlo).
- mdStartE  in  1  E holds mult/multu/div/divu this cycle.
- mdIsDivE  in  1  qualifies mdStartE: 1 = div, 0 = mult.
- eretD  in  1  D holds eret.
- mtc0EpcE  in  1  E holds mtc0 targeting EPC.
- mtc0EpcM  in  1  M holds mtc0 targeting EPC.
- weF  out  1  PC write enable.
- weD  out  1  F/D register write enable.
- flushE  out  1  load bubble into D/E register.
- mdBusy  out  1  MDU occupied (counter nonzero or start this cycle).
- stall  out  1  composite stall indicator.

Behaviour:
- MDU FSM:
  - States IDLE, BUSY.
  - IDLE -> BUSY on mdStartE & !Req; counter loads DIV_CYCLES if mdIsDivE, else MULT_CYCLES.
  - BUSY: counter decrements every cycle; BUSY -> IDLE on the edge where counter goes 1 -> 0.
  - mdStartE while BUSY: the counter reloads from mdStartE/mdIsDivE as in IDLE. This cannot occur when stall works, but it is defined.
  - Req does not abort a BUSY counter, because the issued op is committed. Req does block a new load.
  - Reset: state IDLE, counter 0.
- mdBusy = (state==BUSY) | (mdStartE & !Req).
- Hazard terms, all combinational:
  - stallRs = rsD!=0 & tuseRsD!=3 & ((rsD==a3E & tnewE>tuseRsD) | (rsD==a3M & tnewM>tuseRsD)).
  - stallRt is the same form for rt.
  - stallMd = mdD & mdBusy.
  - stallEret = eretD & (mtc0EpcE | mtc0EpcM).
- stall = (stallRs | stallRt | stallMd | stallEret) & !Req.
- Outputs:
  - weF = !stall.
  - weD = !stall.
  - flushE = stall | Req.
  - With Req=1: weF=1, weD=1, flushE=1, stall=0. The D register self-clears and loads PC 0x4180 on Req.
- Latency: all enables are combinational, valid in the same cycle as inputs; only the MDU counter/FSM is registered.
- During reset assertion: state IDLE, counter 0, so outputs follow combinationally from the inputs. With no hazard inputs active: weF=1, weD=1, flushE=0, mdBusy=0, stall=0.
- Reset mid-BUSY: counter clears immediately (async); mdBusy drops without waiting for a clock edge.
- a3E/a3M equal to 0 never cause a stall, even when rsD=0 is excluded redundantly.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- When defined:
  - adds outputs stallCycles[31:0] and mdStallCycles[31:0], both reset 0;
  - stallCycles increments each clk where stall=1;
  - mdStallCycles increments each clk where stallMd & !Req;
  - both counters wrap 0xFFFFFFFF -> 0.
- When undefined: the ports and registers are absent; all other behaviour is identical.

Test Plan:
- RAW on load: a3E=8, tnewE=2, rsD=8, tuseRsD=1 -> stall=1, weF=0, weD=0, flushE=1. Same with tnewE=1 -> stall=0.
- $0 guard: a3E=0, rsD=0, tnewE=2, tuseRsD=0 -> stall=0.
- Mult then mfhi:
  - mdStartE=1, mdIsDivE=0 for one cycle, then mdD=1 held.
  - stall=1 for 6 cycles total: the issue cycle plus 5 BUSY cycles.
  - Released on the cycle after the counter reaches 0.
  - Repeat with div -> 11 cycles.
- Req cancels start: mdStartE=1 & Req=1 same cycle -> state stays IDLE, mdBusy=0 next cycle, flushE=1, weF=1.
- Eret ordering: eretD=1, mtc0EpcM=1 -> stall=1. Next cycle mtc0EpcM=0 -> stall=0.
- Async reset mid-div: assert reset 3 cycles into BUSY -> mdBusy=0 before next clk edge. After release, mdD=1 -> stall=0. With STALL_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//
// Central stall/flush controller for the five-stage MIPS pipeline. It drives
// the F/D write enables and the E-stage bubble from three stall sources:
//   - register data hazards (Tuse/Tnew comparison against the E and M
//     destination registers),
//   - multiply/divide unit occupancy, tracked by a small IDLE/BUSY FSM with a
//     down-counter,
//   - eret in D while an mtc0 to EPC is still in flight in E or M.
// An exception request from CP0 (Req) overrides every stall. It flushes E and
// cancels a mult/div that is starting in E in the same cycle.
//
// All enables are combinational. Only the MDU FSM/counter is registered.
//
// Optional feature: when the macro STALL_PERF_CNT_EN is defined, the block
// gains two 32-bit wrapping performance counters, stallCycles and
// mdStallCycles. When the macro is undefined, those ports and registers are
// absent.
//
// Ports:
//   clk            clock
//   reset          asynchronous active-high reset
//   Req            exception/interrupt request (flush all)
//   rsD, rtD       source register indices of the D instruction
//   tuseRsD/RtD    cycles until rs/rt is needed (3 = operand unused)
//   a3E, tnewE     destination / result latency of the E instruction
//   a3M, tnewM     destination / result latency of the M instruction
//   mdD            D instruction uses the MDU
//   mdStartE       E holds mult/multu/div/divu
//   mdIsDivE       qualifies mdStartE: 1 = divide, 0 = multiply
//   eretD          D holds eret
//   mtc0EpcE/M     E/M holds an mtc0 that writes EPC
//   weF, weD       PC and F/D register write enables
//   flushE         load a bubble into the D/E register
//   mdBusy         MDU occupied (BUSY, or a start accepted this cycle)
//   stall          composite stall indicator
//   stallCycles    (STALL_PERF_CNT_EN) cycles with stall=1
//   mdStallCycles  (STALL_PERF_CNT_EN) cycles stalled on the MDU
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Req,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [1:0] tuseRsD,
    input  logic [1:0] tuseRtD,
    input  logic [4:0] a3E,
    input  logic [1:0] tnewE,
    input  logic [4:0] a3M,
    input  logic [1:0] tnewM,
    input  logic       mdD,
    input  logic       mdStartE,
    input  logic       mdIsDivE,
    input  logic       eretD,
    input  logic       mtc0EpcE,
    input  logic       mtc0EpcM,
    output logic       weF,
    output logic       weD,
    output logic       flushE,
    output logic       mdBusy,
    output logic       stall
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] stallCycles,
    output logic [31:0] mdStallCycles
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic md_accept;   // start accepted this cycle (not cancelled by Req)
    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall_eret;
    logic stall_any;

    assign md_accept = mdStartE & ~Req;

    // -----------------------------------------------------------------------
    // MDU FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so that every
    // always_ff samples pre-edge values, independent of evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // MDU FSM: next state
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;

        if (md_accept) begin
            // A new op loads the counter in either state. While BUSY this
            // should be prevented by the stall, but it is defined as a reload.
            cnt_next   = mdIsDivE ? DIV_LOAD : MULT_LOAD;
            state_next = (cnt_next != '0) ? BUSY : IDLE;
        end else if (state == BUSY) begin
            // Req does not abort an issued op. The counter keeps running.
            cnt_next = cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                state_next = IDLE;
            end
        end
    end

    assign mdBusy = (state == BUSY) | md_accept;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    // A source register stalls D when a producer in E or M writes it and the
    // producer's result arrives later than the consumer needs it. $0 is never
    // a real dependency. Checking src != 0 also rules out a3E/a3M == 0.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] a3_e,
        input logic [1:0] tnew_e,
        input logic [4:0] a3_m,
        input logic [1:0] tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == a3_e) && (tnew_e > tuse);
        hit_m = (src == a3_m) && (tnew_m > tuse);
        return (src != 5'd0) && (tuse != 2'd3) && (hit_e || hit_m);
    endfunction

    assign stall_rs   = src_hazard(rsD, tuseRsD, a3E, tnewE, a3M, tnewM);
    assign stall_rt   = src_hazard(rtD, tuseRtD, a3E, tnewE, a3M, tnewM);
    assign stall_md   = mdD & mdBusy;
    // eret reads EPC in D, so it must wait until no mtc0 to EPC is pending.
    assign stall_eret = eretD & (mtc0EpcE | mtc0EpcM);

    assign stall_any = stall_rs | stall_rt | stall_md | stall_eret;

    // -----------------------------------------------------------------------
    // Outputs. Req wins: F and D keep advancing (the D register self-clears
    // and F loads the handler PC) while E receives a bubble.
    // -----------------------------------------------------------------------
    assign stall  = stall_any & ~Req;
    assign weF    = ~stall;
    assign weD    = ~stall;
    assign flushE = stall | Req;

`ifdef STALL_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^32)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCycles   <= '0;
            mdStallCycles <= '0;
        end else begin
            if (stall) begin
                stallCycles <= stallCycles + 32'd1;
            end
            if (stall_md & ~Req) begin
                mdStallCycles <= mdStallCycles + 32'd1;
            end
        end
    end
`endif

endmodule
